stp_fsm_param: RTL and testbench
================================

STP_FSM_PARAM -- requirements
Module: stp_fsm_param

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, coefficient width.
REQ-002 SHALL have parameter BUFFER_SIZE, default 1024, data RAM depth; BW = clog2(BUFFER_SIZE).
REQ-003 SHALL have parameter NUM_POLY, default 8, polynomial slots; AW = clog2(NUM_POLY).
REQ-004 SHALL have parameter MAX_DEG, default 10, maximum degree. Derived values: NW = clog2(MAX_DEG+2); S_SIZE = NUM_POLY*(MAX_DEG+1); SW = clog2(S_SIZE).
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  in  1  clock; one clock domain only.
  rst  in  1  reset; asynchronous, active-low.
  rst_instr  in  1  instruction abort; synchronous, active-low.
  start_stp  in  1  one-cycle start; sampled only in IDLE.
  A  in  AW+1  target slot index.
  N  in  NW+1  polynomial degree; N+1 coefficients follow.
  rd_addr_data  in  BW  current data RAM read pointer.
  data_empty  in  1  high = no coefficient available; reads stall.
  next_c  in  WORD_SIZE  data RAM output; valid the cycle after en_rd_data.
  fifo_full_r, fifo_full_s  in  1 each  result/status FIFO full.
  en_rd_data  out  1  data RAM read strobe.
  rd_addr_data_updated  out  BW  read address / returned pointer.
  en_wr_S, wr_addr_S, c  out  1/SW/WORD_SIZE  S RAM write port.
  en_wr_N, wr_addr_N, N_out  out  1/AW/NW  N RAM write port.
  result, status  out  32 each  FIFO data.
  fifo_wr_en_r, fifo_wr_en_s  out  1 each  FIFO push strobes.
  done_stp  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement states IDLE, CHECK, STREAM, DRAIN, REPORT, DONE; all outputs are registered.
REQ-007 In IDLE, start_stp=1 SHALL latch A, N and rd_addr_data and go to CHECK; start_stp in any other state SHALL be ignored.
REQ-008 CHECK SHALL flag an error and go to REPORT when A >= NUM_POLY (status 2) or N > MAX_DEG (status 1); the A check takes priority. Otherwise it SHALL go to STREAM.
REQ-009 STREAM SHALL assert en_rd_data in every cycle with data_empty=0, incrementing rd_addr_data_updated after each read, until N+1 reads are issued, then go to DRAIN. Cycles with data_empty=1 SHALL issue no read and hold the pointer.
REQ-010 Each read SHALL produce exactly one registered S write two cycles later: en_wr_S=1, c=next_c, wr_addr_S = A*(MAX_DEG+1)+k for the k-th coefficient (k=0..N). Index arithmetic SHALL be in SW bits with no wrap.
REQ-011 en_wr_N SHALL pulse exactly once, in the cycle of the final S write, with wr_addr_N=A and N_out=N. The degree is committed only after all coefficients are written.
REQ-012 DRAIN SHALL wait until the final S write has been issued, then go to REPORT.
REQ-013 REPORT SHALL hold while fifo_full_r or fifo_full_s is 1. Otherwise it SHALL pulse fifo_wr_en_r and fifo_wr_en_s together in one cycle, then go to DONE.
REQ-014 On success: result = N+1, status = 0. On error: result = 0, no RAM reads or writes, and rd_addr_data_updated = the latched rd_addr_data.
REQ-015 DONE SHALL pulse done_stp for one cycle and return to IDLE. On success, rd_addr_data_updated SHALL equal the latched pointer + N + 1, modulo BUFFER_SIZE (wrap allowed).
REQ-016 Latency with no stall and no full FIFO, start sampled at edge k: first read k+2, last S write k+4+N, FIFO push k+5+N, done_stp k+6+N. For an error: FIFO push k+2, done_stp k+3.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE and set: all strobes 0, addresses 0, c=0, N_out=0, result=0, status=32'hFFFFFFFF.
REQ-018 rst_instr=0 SHALL, at the next edge, force the same values; in-flight reads SHALL produce no S or N write and no FIFO push.

Structure
REQ-019 Package stp_pkg SHALL hold the state encoding, the status codes (OK=0, BAD_DEG=1, BAD_IDX=2), the clog2 function and the derived-width helpers.
REQ-020 The two-stage read-to-write pipeline SHALL be sub-module stp_wr_pipe, which carries the valid, index, last flag and coefficient.

Verification
REQ-021 A=3, N=4, rd_addr_data=100, no stalls -> S writes at 33..37 with data RAM words 100..104; N write (3,4); result=5, status=0; pointer returned = 105; done_stp at k+10.
REQ-022 A=1, N=11 -> status=1, result=0, zero RAM strobes, pointer unchanged, done_stp at k+3.
REQ-023 A=8 (NUM_POLY=8), N=12 -> status=2 (index check takes priority).
REQ-024 N=2, data_empty high for 3 cycles mid-stream -> exactly 3 ordered S writes, each address once, done_stp delayed by 3 cycles.
REQ-025 fifo_full_s held high 5 cycles in REPORT -> no push until it drops, then one simultaneous push of both FIFOs.
REQ-026 rst_instr pulsed low during STREAM -> no further en_wr_S or en_wr_N, no FIFO push, IDLE next cycle; a following start completes normally.

Source files
------------

// File: rtl/stp_pkg.sv
// stp_pkg: shared types and helpers for the store-polynomial block.
//   state_e  : controller states
//   stat_e   : status codes pushed to the status FIFO
//   clog2 and the derived-width helpers used in parameter lists
package stp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STREAM,
    S_DRAIN,
    S_REPORT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BAD_DEG = 2'd1,
    ST_BAD_IDX = 2'd2
  } stat_e;

  localparam logic [31:0] STATUS_RST = 32'hFFFF_FFFF;

  // Ceiling log2, never below 1 so every derived bus is at least one bit wide.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int bw_f(input int buffer_size);
    return clog2(buffer_size);
  endfunction

  function automatic int aw_f(input int num_poly);
    return clog2(num_poly);
  endfunction

  // N must hold MAX_DEG+1 values (0..MAX_DEG) plus room for an out-of-range request.
  function automatic int nw_f(input int max_deg);
    return clog2(max_deg + 2);
  endfunction

  function automatic int sw_f(input int num_poly, input int max_deg);
    return clog2(num_poly * (max_deg + 1));
  endfunction

endpackage

// File: rtl/stp_wr_pipe.sv
// stp_wr_pipe: two-stage read-to-write pipeline.
//   Stage 1 follows the data RAM read strobe (index + last flag).
//   Stage 2 captures the RAM word (valid one cycle after the read) and
//   presents the S RAM write.
// Ports:
//   clk, rst        clock, async active-low reset
//   flush_i         synchronous clear (instruction abort)
//   vld_i/idx_i/last_i  registered read strobe, S index, final-coefficient flag
//   next_c_i        data RAM output
//   wr_en_o/wr_addr_o/c_o  S RAM write port
//   s1_last_o       final coefficient is in stage 1 (write issues next edge)
module stp_wr_pipe #(
  parameter int WORD_SIZE = 16,
  parameter int SW        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 vld_i,
  input  logic [SW-1:0]        idx_i,
  input  logic                 last_i,
  input  logic [WORD_SIZE-1:0] next_c_i,
  output logic                 wr_en_o,
  output logic [SW-1:0]        wr_addr_o,
  output logic [WORD_SIZE-1:0] c_o,
  output logic                 s1_last_o
);

  logic [1:0]           vld_pipe;
  logic [SW-1:0]        idx_q;
  logic                 last_q;
  logic [SW-1:0]        wr_addr_q;
  logic [WORD_SIZE-1:0] c_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
      c_q       <= '0;
    end else if (flush_i) begin
      vld_pipe  <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
      c_q       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], vld_i};
      idx_q    <= idx_i;
      last_q   <= vld_i & last_i;
      // Address/data only move on a real write so the port holds its last value.
      if (vld_pipe[0]) begin
        wr_addr_q <= idx_q;
        c_q       <= next_c_i;
      end
    end
  end

  assign wr_en_o   = vld_pipe[1];
  assign wr_addr_o = wr_addr_q;
  assign c_o       = c_q;
  assign s1_last_o = vld_pipe[0] & last_q;

endmodule

// File: rtl/stp_fsm_param.sv
// stp_fsm_param: store one polynomial (N+1 coefficients) from the data RAM
// into slot A of the S RAM, commit its degree to the N RAM, then report
// result/status through two FIFOs.
// Ports:
//   clk, rst            clock, async active-low reset
//   rst_instr           sync active-low instruction abort
//   start_stp, A, N, rd_addr_data   command (sampled in IDLE)
//   data_empty, next_c  data RAM status / read data
//   fifo_full_r/_s      FIFO back-pressure
//   en_rd_data, rd_addr_data_updated   data RAM read port / returned pointer
//   en_wr_S, wr_addr_S, c              S RAM write port
//   en_wr_N, wr_addr_N, N_out          N RAM write port
//   result, status, fifo_wr_en_r/_s    FIFO pushes
//   done_stp            one-cycle completion pulse
// All outputs come straight from registers.
module stp_fsm_param
  import stp_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int BUFFER_SIZE = 1024,
  parameter int NUM_POLY    = 8,
  parameter int MAX_DEG     = 10,
  localparam int BW = bw_f(BUFFER_SIZE),
  localparam int AW = aw_f(NUM_POLY),
  localparam int NW = nw_f(MAX_DEG),
  localparam int SW = sw_f(NUM_POLY, MAX_DEG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_instr,
  input  logic                 start_stp,
  input  logic [AW:0]          A,
  input  logic [NW:0]          N,
  input  logic [BW-1:0]        rd_addr_data,
  input  logic                 data_empty,
  input  logic [WORD_SIZE-1:0] next_c,
  input  logic                 fifo_full_r,
  input  logic                 fifo_full_s,
  output logic                 en_rd_data,
  output logic [BW-1:0]        rd_addr_data_updated,
  output logic                 en_wr_S,
  output logic [SW-1:0]        wr_addr_S,
  output logic [WORD_SIZE-1:0] c,
  output logic                 en_wr_N,
  output logic [AW-1:0]        wr_addr_N,
  output logic [NW-1:0]        N_out,
  output logic [31:0]          result,
  output logic [31:0]          status,
  output logic                 fifo_wr_en_r,
  output logic                 fifo_wr_en_s,
  output logic                 done_stp
);

  localparam logic [AW:0]   NP_L   = (AW+1)'(NUM_POLY);
  localparam logic [NW:0]   MD_L   = (NW+1)'(MAX_DEG);
  localparam logic [NW:0]   ONE_N  = (NW+1)'(1);
  localparam logic [SW-1:0] STRIDE = SW'(MAX_DEG + 1);

  state_e          state_q, state_d;
  stat_e           code_q, code_d;
  logic [AW:0]     a_q, a_d;
  logic [NW:0]     n_q, n_d;
  logic [BW-1:0]   ptr_q, ptr_d;
  logic [NW:0]     cnt_q, cnt_d;       // reads issued so far
  logic            en_rd_q, en_rd_d;
  logic [SW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;
  logic            en_wr_n_q, en_wr_n_d;
  logic [AW-1:0]   wr_addr_n_q, wr_addr_n_d;
  logic [NW-1:0]   n_out_q, n_out_d;
  logic [31:0]     result_q, result_d;
  logic [31:0]     status_q, status_d;
  logic            fifo_q, fifo_d;
  logic            done_q, done_d;

  logic [SW-1:0]   base;
  logic            s1_last;

  // Slot base in SW bits; A is range-checked before this is ever used.
  assign base = SW'(a_q[AW-1:0]) * STRIDE;

  stp_wr_pipe #(.WORD_SIZE(WORD_SIZE), .SW(SW)) u_wr_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (!rst_instr),
    .vld_i     (en_rd_q),
    .idx_i     (idx_q),
    .last_i    (last_q),
    .next_c_i  (next_c),
    .wr_en_o   (en_wr_S),
    .wr_addr_o (wr_addr_S),
    .c_o       (c),
    .s1_last_o (s1_last)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    a_d         = a_q;
    n_d         = n_q;
    // The pointer advances after every issued read.
    ptr_d       = ptr_q + BW'(en_rd_q);
    cnt_d       = cnt_q;
    en_rd_d     = 1'b0;
    idx_d       = idx_q;
    last_d      = 1'b0;
    // Degree commit lines up with the final S write leaving stage 2.
    en_wr_n_d   = s1_last;
    wr_addr_n_d = s1_last ? a_q[AW-1:0] : wr_addr_n_q;
    n_out_d     = s1_last ? n_q[NW-1:0] : n_out_q;
    result_d    = result_q;
    status_d    = status_q;
    fifo_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_stp) begin
          a_d     = A;
          n_d     = N;
          ptr_d   = rd_addr_data;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (a_q >= NP_L) begin
          code_d  = ST_BAD_IDX;
          state_d = S_REPORT;
        end else if (n_q > MD_L) begin
          code_d  = ST_BAD_DEG;
          state_d = S_REPORT;
        end else begin
          code_d  = ST_OK;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (!data_empty) begin
          en_rd_d = 1'b1;
          idx_d   = base + SW'(cnt_q);
          last_d  = (cnt_q == n_q);
          cnt_d   = cnt_q + ONE_N;
          if (cnt_q == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (s1_last) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (!(fifo_full_r || fifo_full_s)) begin
          fifo_d   = 1'b1;
          result_d = (code_q == ST_OK) ? (32'(n_q) + 32'd1) : 32'd0;
          status_d = 32'(code_q);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Instruction abort wins over everything, including in-flight commits.
    if (!rst_instr) begin
      state_d     = S_IDLE;
      code_d      = ST_OK;
      a_d         = '0;
      n_d         = '0;
      ptr_d       = '0;
      cnt_d       = '0;
      en_rd_d     = 1'b0;
      idx_d       = '0;
      last_d      = 1'b0;
      en_wr_n_d   = 1'b0;
      wr_addr_n_d = '0;
      n_out_d     = '0;
      result_d    = '0;
      status_d    = STATUS_RST;
      fifo_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      code_q      <= ST_OK;
      a_q         <= '0;
      n_q         <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      en_rd_q     <= 1'b0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      en_wr_n_q   <= 1'b0;
      wr_addr_n_q <= '0;
      n_out_q     <= '0;
      result_q    <= '0;
      status_q    <= STATUS_RST;
      fifo_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      a_q         <= a_d;
      n_q         <= n_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      en_rd_q     <= en_rd_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      en_wr_n_q   <= en_wr_n_d;
      wr_addr_n_q <= wr_addr_n_d;
      n_out_q     <= n_out_d;
      result_q    <= result_d;
      status_q    <= status_d;
      fifo_q      <= fifo_d;
      done_q      <= done_d;
    end
  end

  assign en_rd_data           = en_rd_q;
  assign rd_addr_data_updated = ptr_q;
  assign en_wr_N              = en_wr_n_q;
  assign wr_addr_N            = wr_addr_n_q;
  assign N_out                = n_out_q;
  assign result               = result_q;
  assign status               = status_q;
  assign fifo_wr_en_r         = fifo_q;
  assign fifo_wr_en_s         = fifo_q;
  assign done_stp             = done_q;

endmodule

// File: tb/tb_stp_fsm_param.sv
// Randomized + directed bench for stp_fsm_param (default parameters).
// A data RAM model feeds next_c; a negedge monitor collects every RAM write,
// FIFO push and done pulse, and each operation is compared against the
// expected transaction list derived from A, N and the pointer.
module tb_stp_fsm_param;
  localparam int BS = 1024;
  localparam int NP = 8;
  localparam int MD = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_instr = 1'b1;
  logic        start_stp = 1'b0;
  logic [3:0]  A = '0;
  logic [4:0]  N = '0;
  logic [9:0]  rd_addr_data = '0;
  logic        data_empty = 1'b0;
  logic [15:0] next_c = '0;
  logic        fifo_full_r = 1'b0;
  logic        fifo_full_s = 1'b0;
  logic        en_rd_data;
  logic [9:0]  rd_addr_data_updated;
  logic        en_wr_S;
  logic [6:0]  wr_addr_S;
  logic [15:0] c;
  logic        en_wr_N;
  logic [2:0]  wr_addr_N;
  logic [3:0]  N_out;
  logic [31:0] result, status;
  logic        fifo_wr_en_r, fifo_wr_en_s, done_stp;

  stp_fsm_param dut (
    .clk(clk), .rst(rst), .rst_instr(rst_instr), .start_stp(start_stp),
    .A(A), .N(N), .rd_addr_data(rd_addr_data), .data_empty(data_empty),
    .next_c(next_c), .fifo_full_r(fifo_full_r), .fifo_full_s(fifo_full_s),
    .en_rd_data(en_rd_data), .rd_addr_data_updated(rd_addr_data_updated),
    .en_wr_S(en_wr_S), .wr_addr_S(wr_addr_S), .c(c),
    .en_wr_N(en_wr_N), .wr_addr_N(wr_addr_N), .N_out(N_out),
    .result(result), .status(status),
    .fifo_wr_en_r(fifo_wr_en_r), .fifo_wr_en_s(fifo_wr_en_s),
    .done_stp(done_stp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Data RAM model
  logic [15:0] mem [BS];
  logic        rd_s = 1'b0;
  logic [9:0]  addr_s = '0;

  // Monitor state
  int          s_addr_q[$];
  int          s_cyc_q[$];
  logic [15:0] s_dat_q[$];
  int          n_cnt, n_addr, n_val, n_cyc;
  int          push_cnt, push_cyc, push_split;
  logic [31:0] res_seen, stat_seen;
  int          done_cnt, done_cyc, rd_cnt;
  logic [9:0]  ptr_at_done;

  // Stimulus windows (absolute cycle numbers) and random modes
  int st_lo = -1, st_hi = -2, fl_lo = -1, fl_hi = -2;
  bit rand_stall = 0, rand_full = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rd_s) next_c = mem[addr_s];
  end

  initial forever begin
    @(negedge clk);
    rd_s   = en_rd_data;
    addr_s = rd_addr_data_updated;
    if (en_rd_data) rd_cnt++;
    if (en_wr_S) begin
      s_addr_q.push_back(int'(wr_addr_S));
      s_dat_q.push_back(c);
      s_cyc_q.push_back(cyc);
    end
    if (en_wr_N) begin
      n_cnt++; n_addr = int'(wr_addr_N); n_val = int'(N_out); n_cyc = cyc;
    end
    if (fifo_wr_en_r || fifo_wr_en_s) begin
      push_cnt++; push_cyc = cyc; res_seen = result; stat_seen = status;
      if (fifo_wr_en_r != fifo_wr_en_s) push_split++;
    end
    if (done_stp) begin
      done_cnt++; done_cyc = cyc; ptr_at_done = rd_addr_data_updated;
    end
    data_empty  = rand_stall ? ($urandom_range(0, 3) == 0) : (cyc >= st_lo && cyc <= st_hi);
    fifo_full_r = rand_full && ($urandom_range(0, 2) == 0);
    fifo_full_s = (rand_full && ($urandom_range(0, 2) == 0)) || (cyc >= fl_lo && cyc <= fl_hi);
  end

  task automatic clear_mon();
    s_addr_q.delete(); s_dat_q.delete(); s_cyc_q.delete();
    n_cnt = 0; push_cnt = 0; push_split = 0; done_cnt = 0; rd_cnt = 0;
  endtask

  // Launch one instruction and return the edge that sampled start.
  task automatic launch(input int a, input int n, input int ptr, output int k);
    @(negedge clk); #1;
    clear_mon();
    A = 4'(a); N = 5'(n); rd_addr_data = 10'(ptr); start_stp = 1'b1;
    @(negedge clk); #1;
    k = cyc;
    start_stp = 1'b0;
    // Scramble the command inputs: the block must use its latched copy.
    A = 4'($urandom); N = 5'($urandom); rd_addr_data = 10'($urandom);
  endtask

  task automatic run_op(input int a, input int n, input int ptr, input int exp_lat,
                        input int st_off, input int st_len, input int fl_off, input int fl_len);
    int k, t, err;
    string tg;
    launch(a, n, ptr, k);
    if (st_len > 0) begin st_lo = k + st_off; st_hi = k + st_off + st_len - 1; end
    if (fl_len > 0) begin fl_lo = k + fl_off; fl_hi = k + fl_off + fl_len - 1; end
    t = 0;
    while (done_cnt == 0 && t < 400) begin @(negedge clk); #1; t++; end
    repeat (4) begin @(negedge clk); #1; end
    st_lo = -1; st_hi = -2; fl_lo = -1; fl_hi = -2;
    tg = $sformatf("a%0d_n%0d_p%0d", a, n, ptr);
    chk({tg, " done_count"}, done_cnt, 1);
    chk({tg, " push_count"}, push_cnt, 1);
    chk({tg, " push_split"}, push_split, 0);
    err = (a >= NP) ? 2 : ((n > MD) ? 1 : 0);
    chk({tg, " status"}, stat_seen, err);
    if (err == 0) begin
      chk({tg, " result"}, res_seen, n + 1);
      chk({tg, " s_count"}, s_addr_q.size(), n + 1);
      if (s_addr_q.size() == n + 1) begin
        for (int i = 0; i <= n; i++) begin
          chk($sformatf("%s s_addr%0d", tg, i), s_addr_q[i], a * (MD + 1) + i);
          chk($sformatf("%s s_data%0d", tg, i), s_dat_q[i], mem[(ptr + i) % BS]);
        end
        chk({tg, " n_with_last_s"}, n_cyc, s_cyc_q[n]);
      end
      chk({tg, " n_count"}, n_cnt, 1);
      chk({tg, " n_addr"}, n_addr, a);
      chk({tg, " n_val"}, n_val, n);
      chk({tg, " ptr_ret"}, ptr_at_done, (ptr + n + 1) % BS);
    end else begin
      chk({tg, " result"}, res_seen, 0);
      chk({tg, " rd_count"}, rd_cnt, 0);
      chk({tg, " s_count"}, s_addr_q.size(), 0);
      chk({tg, " n_count"}, n_cnt, 0);
      chk({tg, " ptr_ret"}, ptr_at_done, ptr);
    end
    if (exp_lat >= 0) begin
      chk({tg, " done_lat"}, done_cyc - k, exp_lat);
      chk({tg, " push_lat"}, push_cyc - k, exp_lat - 1);
    end
  endtask

  initial begin
    int k, ka, late;
    for (int i = 0; i < BS; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst en_rd", en_rd_data, 0);
    chk("rst en_wr_S", en_wr_S, 0);
    chk("rst wr_addr_S", wr_addr_S, 0);
    chk("rst c", c, 0);
    chk("rst en_wr_N", en_wr_N, 0);
    chk("rst N_out", N_out, 0);
    chk("rst ptr", rd_addr_data_updated, 0);
    chk("rst result", result, 0);
    chk("rst status", status, 32'hFFFF_FFFF);
    chk("rst push", fifo_wr_en_r | fifo_wr_en_s, 0);
    chk("rst done", done_stp, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    run_op(3, 4, 100, 10, 0, 0, 0, 0);     // nominal
    run_op(1, 11, 200, 3, 0, 0, 0, 0);     // bad degree
    run_op(8, 12, 300, 3, 0, 0, 0, 0);     // bad index takes priority
    run_op(5, 2, 300, 11, 2, 3, 0, 0);     // 3-cycle stall mid-stream
    run_op(0, 2, 400, 13, 0, 0, 6, 5);     // status FIFO full 5 cycles in REPORT
    run_op(7, 10, 1020, 16, 0, 0, 0, 0);   // largest slot/degree, pointer wrap
    run_op(0, 0, 5, 6, 0, 0, 0, 0);        // single coefficient

    // Abort during STREAM
    launch(2, 6, 50, k);
    while (cyc < k + 4) begin @(negedge clk); #1; end
    rst_instr = 1'b0;
    @(negedge clk); #1;
    ka = cyc;
    rst_instr = 1'b1;
    chk("abort en_rd", en_rd_data, 0);
    chk("abort en_wr_S", en_wr_S, 0);
    chk("abort status", status, 32'hFFFF_FFFF);
    chk("abort ptr", rd_addr_data_updated, 0);
    repeat (20) begin @(negedge clk); #1; end
    late = 0;
    foreach (s_cyc_q[i]) if (s_cyc_q[i] >= ka) late++;
    chk("abort late_s", late, 0);
    chk("abort n_count", n_cnt, 0);
    chk("abort push", push_cnt, 0);
    chk("abort done", done_cnt, 0);
    run_op(6, 3, 700, 9, 0, 0, 0, 0);

    // Randomized commands with random stalls and FIFO back-pressure
    rand_stall = 1; rand_full = 1;
    for (int i = 0; i < 30; i++)
      run_op($urandom_range(0, 9), $urandom_range(0, 12), $urandom_range(0, BS - 1), -1, 0, 0, 0, 0);
    rand_stall = 0; rand_full = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
